sc_config_ctrl: RTL and testbench
=================================

Name: sc_config_ctrl

Overview:
- Configuration sequencer for the scanconverter output timing/scaling registers.
- Accepts register writes from the control CPU into shadow registers.
- Commits all shadows atomically at the start of output vertical sync.
- Blanks output for a settle period after each commit, then flags stable; sits between the CPU register bridge and scanconverter config inputs.

Parameters:
SETTLE_FRAMES, 2, output vsync edges after commit before blank_o deasserts (1..15)
TIMEOUT_CYCLES, 2000000, PCLK cycles waiting for vsync before forced commit

Ports:
PCLK_i  in  1  output pixel clock, single clock domain
reset  in  1  asynchronous, active-high reset
wr_valid_i  in  1  CPU write request
wr_ready_o  out  1  write accepted when wr_valid_i & wr_ready_o
wr_addr_i  in  3  0=h_out_config,1=h_out_config2,2=v_out_config,3=v_out_config2,4=xy_out_config,5=misc_config; 6,7 ignored
wr_data_i  in  32  write data
commit_req_i  in  1  pulse/level: request commit of shadows
commit_busy_o  out  1  high from commit acceptance until return to IDLE
VSYNC_i  in  1  scanconverter VSYNC_o (active-low)
resync_strobe_i  in  1  scanconverter resync_strobe
h_out_config_o, h_out_config2_o, v_out_config_o, v_out_config2_o, xy_out_config_o, misc_config_o  out  32 each  active config to scanconverter
blank_o  out  1  force output mask
stable_o  out  1  config applied and settled
timeout_o  out  1  sticky: last commit was forced by timeout

Behaviour:
- Reset (async): all shadow and active regs 0; state IDLE; wr_ready_o=1, commit_busy_o=0, blank_o=1, stable_o=0, timeout_o=0; vsync edge register=1; counters 0.
- VSYNC edge: vs_fall = vs_prev & ~VSYNC_i, vs_prev registered every cycle. resync_rise likewise on resync_strobe_i.
- Writes: accepted only in IDLE (wr_ready_o = state==IDLE, combinational from state). Accepted write updates shadow[wr_addr_i] on that edge; addr 6/7 accepted and discarded. Active regs never change on a write.
- States:
  - IDLE: commit_req_i=1 -> WAIT_VS; commit_busy_o=1 next cycle; timeout counter cleared. A write and commit_req_i in the same cycle: write lands in shadow and is included in the commit.
  - WAIT_VS: wr_ready_o=0; timeout counter increments. On vs_fall -> APPLY. If counter reaches TIMEOUT_CYCLES-1 without vs_fall -> APPLY with timeout_o set. vs_fall wins on the same cycle, and timeout_o is cleared.
  - APPLY (exactly 1 cycle): all six active regs <= shadows on the same edge; blank_o=1, stable_o=0; settle counter=0 -> SETTLE.
  - SETTLE: each vs_fall increments the settle counter. resync_rise resets the counter to 0, since the scanconverter re-locked its timing. When the counter equals SETTLE_FRAMES -> IDLE, same edge blank_o=0, stable_o=1, commit_busy_o=0.
- blank_o/stable_o are registered. They change only in APPLY (blank 1/stable 0) and on SETTLE exit (blank 0/stable 1).
- commit_req_i is ignored outside IDLE; no queuing. The CPU must poll commit_busy_o.
- timeout_o is updated only in APPLY.
- Counters: timeout 21 bits, saturating-free and cleared on entry to WAIT_VS. Settle counter 4 bits.
- Latency: vs_fall detected at cycle N -> active regs valid at edge N+1 -> blank_o=0 after SETTLE_FRAMES further vs_fall.
- Reset mid-commit: immediate return to reset values. Active config goes to 0; the scanconverter sees zeroed config until the next commit.

Test Plan:
- Reset, write addr0=0x1234_5678, addr2=0xCAFE_0001 -> shadows updated, active outputs remain 0, wr_ready_o=1, blank_o=1.
- commit_req with VSYNC_i toggling, falling edge at cycle 100 -> all actives equal shadows at cycle 102, commit_busy_o=1 throughout; wr_valid_i during WAIT_VS not accepted.
- SETTLE_FRAMES=2: after APPLY, two vs_fall -> blank_o=0, stable_o=1, commit_busy_o=0 on the edge after the 2nd fall. resync_rise between them -> three total falls required after the resync.
- VSYNC_i held high, TIMEOUT_CYCLES=50 -> APPLY 50 cycles after entry, timeout_o=1. Next commit with a vsync edge -> timeout_o=0.
- Same-cycle write addr4=0xAA and commit_req -> xy_out_config_o=0xAA after commit. Write to addr 7 changes no register.
- Assert reset during SETTLE -> next cycle actives 0, blank_o=1, stable_o=0, wr_ready_o=1, state IDLE.

Source files
------------

// File: rtl/sc_config_ctrl.sv
// Shadows CPU config writes and commits them atomically to the scanconverter at output vsync.
// Commit lands 2 PCLK after a vsync fall (or a timeout); writes backpressured (wr_ready_o=0) while busy.
module sc_config_ctrl #(
    parameter int SETTLE_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        PCLK_i,
    input  logic        reset,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    input  logic [2:0]  wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic        commit_req_i,
    output logic        commit_busy_o,
    input  logic        VSYNC_i,
    input  logic        resync_strobe_i,
    output logic [31:0] h_out_config_o,
    output logic [31:0] h_out_config2_o,
    output logic [31:0] v_out_config_o,
    output logic [31:0] v_out_config2_o,
    output logic [31:0] xy_out_config_o,
    output logic [31:0] misc_config_o,
    output logic        blank_o,
    output logic        stable_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {IDLE, WAIT_VS, APPLY, SETTLE} state_t;

    localparam logic [20:0] TO_LAST  = 21'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  SETTLE_N = 4'(SETTLE_FRAMES);

    state_t            state, state_nxt;
    logic [5:0][31:0]  shadow;
    logic [5:0][31:0]  active;
    logic              vs_prev, rs_prev;
    logic              vs_fall, resync_rise;
    logic [20:0]       to_cnt;
    logic              to_flag;
    logic [3:0]        settle_cnt, settle_nxt;

    assign vs_fall       = vs_prev & ~VSYNC_i;
    assign resync_rise   = resync_strobe_i & ~rs_prev;
    assign wr_ready_o    = (state == IDLE);
    assign commit_busy_o = (state != IDLE);

    assign h_out_config_o  = active[0];
    assign h_out_config2_o = active[1];
    assign v_out_config_o  = active[2];
    assign v_out_config2_o = active[3];
    assign xy_out_config_o = active[4];
    assign misc_config_o   = active[5];

    // A resync means the scanconverter re-locked, so settling restarts from zero.
    always_comb begin
        settle_nxt = settle_cnt;
        if (resync_rise)
            settle_nxt = 4'd0;
        else if (vs_fall)
            settle_nxt = settle_cnt + 4'd1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (commit_req_i) state_nxt = WAIT_VS;
            WAIT_VS: if (vs_fall || to_cnt == TO_LAST) state_nxt = APPLY;
            APPLY:   state_nxt = SETTLE;
            SETTLE:  if (settle_nxt == SETTLE_N) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK_i or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shadow     <= '0;
            active     <= '0;
            vs_prev    <= 1'b1;
            rs_prev    <= 1'b1;
            to_cnt     <= '0;
            to_flag    <= 1'b0;
            settle_cnt <= '0;
            blank_o    <= 1'b1;
            stable_o   <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            state   <= state_nxt;
            vs_prev <= VSYNC_i;
            rs_prev <= resync_strobe_i;
            if (wr_valid_i && wr_ready_o && wr_addr_i < 3'd6)
                shadow[wr_addr_i] <= wr_data_i;
            case (state)
                IDLE: begin
                    if (commit_req_i) begin
                        to_cnt  <= '0;
                        to_flag <= 1'b0;
                    end
                end
                WAIT_VS: begin
                    to_cnt <= to_cnt + 21'd1;
                    if (!vs_fall && to_cnt == TO_LAST)
                        to_flag <= 1'b1;
                end
                APPLY: begin
                    active     <= shadow;
                    blank_o    <= 1'b1;
                    stable_o   <= 1'b0;
                    timeout_o  <= to_flag;
                    settle_cnt <= '0;
                end
                SETTLE: begin
                    settle_cnt <= settle_nxt;
                    if (settle_nxt == SETTLE_N) begin
                        blank_o  <= 1'b0;
                        stable_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_config_ctrl.sv
// Bench for sc_config_ctrl: directed table, corner sequences and a randomized commit/settle model.
module tb_sc_config_ctrl;

    localparam int SF = 2;
    localparam int TO = 50;

    logic        PCLK_i = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid_i = 1'b0;
    logic        wr_ready_o;
    logic [2:0]  wr_addr_i = '0;
    logic [31:0] wr_data_i = '0;
    logic        commit_req_i = 1'b0;
    logic        commit_busy_o;
    logic        VSYNC_i = 1'b1;
    logic        resync_strobe_i = 1'b0;
    logic [31:0] h_out_config_o, h_out_config2_o, v_out_config_o, v_out_config2_o;
    logic [31:0] xy_out_config_o, misc_config_o;
    logic        blank_o, stable_o, timeout_o;

    sc_config_ctrl #(.SETTLE_FRAMES(SF), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK_i(PCLK_i), .reset(reset),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .commit_req_i(commit_req_i), .commit_busy_o(commit_busy_o),
        .VSYNC_i(VSYNC_i), .resync_strobe_i(resync_strobe_i),
        .h_out_config_o(h_out_config_o), .h_out_config2_o(h_out_config2_o),
        .v_out_config_o(v_out_config_o), .v_out_config2_o(v_out_config2_o),
        .xy_out_config_o(xy_out_config_o), .misc_config_o(misc_config_o),
        .blank_o(blank_o), .stable_o(stable_o), .timeout_o(timeout_o)
    );

    always #5 PCLK_i = ~PCLK_i;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
        int          delay;     // vsync fall this many cycles into WAIT_VS; -1 = never (timeout)
        int          exp_idx;
        logic [31:0] exp_val;
        logic        exp_to;
    } vec_t;

    vec_t vecs[7];
    logic [31:0] model_sh[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endtask

    function automatic logic [31:0] act(input int i);
        case (i)
            0: return h_out_config_o;
            1: return h_out_config2_o;
            2: return v_out_config_o;
            3: return v_out_config2_o;
            4: return xy_out_config_o;
            default: return misc_config_o;
        endcase
    endfunction

    task automatic tick();
        @(posedge PCLK_i);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        wr_valid_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        tick();
        wr_valid_i = 1'b0;
    endtask

    task automatic vs_pulse();
        VSYNC_i = 1'b0;
        tick();
        VSYNC_i = 1'b1;
        tick();
    endtask

    task automatic resync();
        resync_strobe_i = 1'b1;
        tick();
        resync_strobe_i = 1'b0;
        tick();
    endtask

    task automatic do_commit(input int delay);
        commit_req_i = 1'b1;
        tick();
        commit_req_i = 1'b0;
        if (delay < 0) repeat (TO + 5) tick();
        else begin
            repeat (delay) tick();
            vs_pulse();
        end
    endtask

    initial begin
        vecs[0] = '{3'd0, 32'h1111_2222, 3,  0, 32'h1111_2222, 1'b0};
        vecs[1] = '{3'd2, 32'hCAFE_0002, 10, 2, 32'hCAFE_0002, 1'b0};
        vecs[2] = '{3'd1, 32'hDEAD_BEEF, -1, 1, 32'hDEAD_BEEF, 1'b1};
        vecs[3] = '{3'd3, 32'h0F0F_0F0F, 49, 3, 32'h0F0F_0F0F, 1'b0};
        vecs[4] = '{3'd5, 32'hFFFF_FFFF, 0,  5, 32'hFFFF_FFFF, 1'b0};
        vecs[5] = '{3'd7, 32'h5555_5555, 5,  0, 32'h1111_2222, 1'b0};
        vecs[6] = '{3'd4, 32'h0000_1357, -1, 4, 32'h0000_1357, 1'b1};

        tick(); tick();
        reset = 1'b0;
        tick();

        check("rst_wr_ready", wr_ready_o, 1);
        check("rst_busy", commit_busy_o, 0);
        check("rst_blank", blank_o, 1);
        check("rst_stable", stable_o, 0);
        check("rst_timeout", timeout_o, 0);
        for (int i = 0; i < 6; i++) check($sformatf("rst_act%0d", i), act(i), 0);

        do_write(3'd0, 32'h1234_5678);
        do_write(3'd2, 32'hCAFE_0001);
        check("pre_commit_h", h_out_config_o, 0);
        check("pre_commit_v", v_out_config_o, 0);
        check("pre_commit_ready", wr_ready_o, 1);
        check("pre_commit_blank", blank_o, 1);

        commit_req_i = 1'b1;
        tick();
        commit_req_i = 1'b0;
        check("wait_busy", commit_busy_o, 1);
        check("wait_ready", wr_ready_o, 0);
        do_write(3'd1, 32'h0000_0999);
        repeat (5) tick();
        VSYNC_i = 1'b0;
        tick();
        check("apply_not_yet", h_out_config_o, 0);
        VSYNC_i = 1'b1;
        tick();
        check("apply_h", h_out_config_o, 32'h1234_5678);
        check("apply_v", v_out_config_o, 32'hCAFE_0001);
        check("wait_write_dropped", h_out_config2_o, 0);
        check("apply_busy", commit_busy_o, 1);
        check("apply_blank", blank_o, 1);
        vs_pulse();
        check("settle1_busy", commit_busy_o, 1);
        resync();
        vs_pulse();
        check("settle_resync_busy", commit_busy_o, 1);
        check("settle_resync_blank", blank_o, 1);
        vs_pulse();
        check("settle_done_busy", commit_busy_o, 0);
        check("settle_done_blank", blank_o, 0);
        check("settle_done_stable", stable_o, 1);
        check("settle_done_timeout", timeout_o, 0);

        for (int v = 0; v < 7; v++) begin
            do_write(vecs[v].addr, vecs[v].data);
            do_commit(vecs[v].delay);
            vs_pulse();
            vs_pulse();
            check($sformatf("vec%0d_val", v), act(vecs[v].exp_idx), vecs[v].exp_val);
            check($sformatf("vec%0d_timeout", v), timeout_o, vecs[v].exp_to);
            check($sformatf("vec%0d_busy", v), commit_busy_o, 0);
            check($sformatf("vec%0d_stable", v), stable_o, 1);
        end

        wr_valid_i = 1'b1; wr_addr_i = 3'd4; wr_data_i = 32'h0000_00AA;
        commit_req_i = 1'b1;
        tick();
        wr_valid_i = 1'b0; commit_req_i = 1'b0;
        vs_pulse();
        vs_pulse();
        vs_pulse();
        check("same_cycle_xy", xy_out_config_o, 32'h0000_00AA);
        check("timeout_cleared", timeout_o, 0);

        for (int i = 0; i < 6; i++) model_sh[i] = act(i);
        for (int it = 0; it < 20; it++) begin
            int nw, falls;
            logic exp_to;
            nw = $urandom_range(3, 0);
            for (int w = 0; w < nw; w++) begin
                logic [2:0]  a;
                logic [31:0] d;
                a = 3'($urandom_range(7, 0));
                d = $urandom;
                do_write(a, d);
                if (a < 3'd6) model_sh[a] = d;
            end
            exp_to = ($urandom_range(4, 0) == 0);
            do_commit(exp_to ? -1 : int'($urandom_range(TO - 1, 0)));
            falls = 0;
            for (int p = 0; p < 8 && falls < SF; p++) begin
                if ($urandom_range(3, 0) == 0) begin
                    resync();
                    falls = 0;
                end
                vs_pulse();
                falls++;
                check($sformatf("rnd%0d_busy_p%0d", it, p), commit_busy_o, (falls < SF) ? 1 : 0);
                check($sformatf("rnd%0d_blank_p%0d", it, p), blank_o, (falls < SF) ? 1 : 0);
            end
            for (int i = 0; i < 6; i++)
                check($sformatf("rnd%0d_act%0d", it, i), act(i), model_sh[i]);
            check($sformatf("rnd%0d_timeout", it), timeout_o, exp_to);
        end

        do_write(3'd5, 32'h0BAD_F00D);
        do_commit(2);
        vs_pulse();
        check("pre_rst_busy", commit_busy_o, 1);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) check($sformatf("midrst_act%0d", i), act(i), 0);
        check("midrst_blank", blank_o, 1);
        check("midrst_stable", stable_o, 0);
        check("midrst_ready", wr_ready_o, 1);
        check("midrst_busy", commit_busy_o, 0);
        check("midrst_timeout", timeout_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
